// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for a tiny accumulator-style CPU: fetches one- or
// two-byte instructions, sequences the ALU/register file and keeps pc and flags.
module cpu_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [2:0]       alu_opcode,
    input  logic             zero_flag_in,
    input  logic             overflow_flag_in,
    output logic [1:0]       rf_ra,
    output logic [1:0]       rf_rb,
    output logic             rf_we,
    output logic [1:0]       rf_wa,
    output logic             rf_wsel,
    output logic [WIDTH-1:0] imm,
    output logic             z_flag,
    output logic             v_flag,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [6:0]       ir;
    logic             we_q;
    logic [2:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs;

    // Only the seven meaningful instruction bits are kept; bit 0 is don't-care.
    assign op = ir[6:4];
    assign rd = ir[3:2];
    assign rs = ir[1:0];

    assign imem_addr = pc;
    assign rf_ra     = rd;
    assign rf_rb     = rs;
    assign rf_wa     = rd;
    assign rf_wsel   = (op == OP_LDI);
    // Reset arriving during EXEC must suppress the write in that same cycle.
    assign rf_we     = we_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            imm        <= '0;
            z_flag     <= 1'b0;
            v_flag     <= 1'b0;
            imem_req   <= 1'b0;
            we_q       <= 1'b0;
            alu_opcode <= OP_ADD;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir       <= imem_data[WIDTH-1 -: 7];
                        pc       <= pc + PC_STEP;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_LDI, OP_JZ, OP_JMP: begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH2;
                        end
                        OP_NOP: begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            we_q       <= 1'b1;
                            alu_opcode <= op;
                            state      <= S_EXEC;
                        end
                    endcase
                end
                S_FETCH2: begin
                    if (imem_req && imem_ack) begin
                        imm      <= imem_data;
                        pc       <= pc + PC_STEP;
                        imem_req <= 1'b0;
                        we_q     <= (op == OP_LDI);
                        state    <= S_EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            z_flag <= zero_flag_in;
                            v_flag <= overflow_flag_in;
                        end
                        OP_JMP: pc <= imm;
                        OP_JZ: begin
                            if (z_flag) pc <= imm;
                        end
                        default: ;
                    endcase
                    we_q       <= 1'b0;
                    alu_opcode <= OP_ADD;
                    imem_req   <= 1'b1;
                    state      <= S_FETCH;
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed program table, hand-written corner
// sequences and random programs checked against an instruction-level model.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [2:0] alu_opcode;
    logic       zero_flag_in;
    logic       overflow_flag_in;
    logic [1:0] rf_ra, rf_rb, rf_wa;
    logic       rf_we, rf_wsel;
    logic [7:0] imm;
    logic       z_flag, v_flag, halted;

    always #5 clk = ~clk;

    cpu_control_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_opcode(alu_opcode),
        .zero_flag_in(zero_flag_in), .overflow_flag_in(overflow_flag_in),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa),
        .rf_wsel(rf_wsel), .imm(imm),
        .z_flag(z_flag), .v_flag(v_flag), .halted(halted)
    );

    logic [7:0] mem [256];
    logic [7:0] hregs [4];
    logic [7:0] initRegs [4];
    logic       loadRegs = 1'b1;
    logic       ackEnable = 1'b0;
    int         ackLimit = 0;
    logic [7:0] gotAddr [$];
    logic [7:0] expAddr [$];
    logic [7:0] aOp, bOp, aluRes;

    int nCompared = 0;
    int nMismatched = 0;

    logic [7:0] mRegs [4];
    logic [7:0] mPc;
    logic       mZ, mV, mHalt;

    typedef struct {
        logic [47:0] prog;
        int          progLen;
        logic [7:0]  hiByte;
        logic [7:0]  rinit;
        int          nFetch;
        logic [7:0]  expPc;
        logic        expZ;
        logic        expV;
        int          regIdx;
        logic [7:0]  expReg;
    } vec_t;

    vec_t vecs [8];

    // Harness ALU: the external datapath the control unit steers.
    always_comb begin
        aOp = hregs[rf_ra];
        bOp = hregs[rf_rb];
        case (alu_opcode)
            3'b001:  aluRes = aOp & bOp;
            3'b010:  aluRes = ~aOp;
            default: aluRes = aOp + bOp;
        endcase
        zero_flag_in     = (aluRes == 8'h00);
        overflow_flag_in = (alu_opcode == 3'b000) && (aOp[7] == bOp[7]) && (aluRes[7] != aOp[7]);
    end

    // Harness register file and fetch-handshake recorder.
    always @(posedge clk) begin
        if (loadRegs) begin
            for (int i = 0; i < 4; i++) hregs[i] <= initRegs[i];
        end else if (rf_we) begin
            hregs[rf_wa] <= rf_wsel ? imm : aluRes;
        end
        if (imem_req && imem_ack) gotAddr.push_back(imem_addr);
    end

    // Memory with random wait states; acks also fire while no request is pending.
    always @(negedge clk) begin
        imem_data <= mem[imem_addr];
        imem_ack  <= ackEnable && (gotAddr.size() < ackLimit) && ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        loadRegs  = 1'b1;
        ackEnable = 1'b0;
        ackLimit  = 0;
        repeat (2) @(posedge clk);
        #1;
        gotAddr.delete();
        checkOutput("resetReq", imem_req, 0);
        checkOutput("resetHalted", halted, 0);
        checkOutput("resetWe", rf_we, 0);
        checkOutput("resetAluOp", alu_opcode, 0);
        checkOutput("resetPcFlags", {imem_addr, z_flag, v_flag}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        loadRegs = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reqFirstCycle", imem_req, 1);
    endtask

    task automatic applyStimulus(input int nFetch);
        int cyc = 0;
        ackLimit  = nFetch;
        ackEnable = 1'b1;
        while (gotAddr.size() < nFetch && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (gotAddr.size() < nFetch) checkOutput("fetchTimeout", gotAddr.size(), nFetch);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic waitRfWe();
        int c = 0;
        while (rf_we !== 1'b1 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("rfWeSeen", rf_we, 1);
    endtask

    function automatic vec_t mkVec(input logic [47:0] prog, input int progLen, input logic [7:0] hiByte,
                                   input logic [7:0] rinit, input int nFetch, input logic [7:0] expPc,
                                   input logic expZ, input logic expV, input int regIdx, input logic [7:0] expReg);
        vec_t v;
        v.prog = prog; v.progLen = progLen; v.hiByte = hiByte; v.rinit = rinit;
        v.nFetch = nFetch; v.expPc = expPc; v.expZ = expZ; v.expV = expV;
        v.regIdx = regIdx; v.expReg = expReg;
        return v;
    endfunction

    // Instruction-level interpreter of the ISA over the bench memory.
    task automatic buildModel();
        logic [7:0] pc, b, imv, r;
        logic [2:0] op;
        logic [1:0] rd, rs;
        for (int i = 0; i < 4; i++) mRegs[i] = initRegs[i];
        mZ = 1'b0; mV = 1'b0; mHalt = 1'b0; pc = 8'h00;
        expAddr.delete();
        for (int k = 0; k < 40 && !mHalt; k++) begin
            b = mem[pc];
            expAddr.push_back(pc);
            pc = pc + 8'd1;
            op = b[7:5]; rd = b[4:3]; rs = b[2:1]; imv = 8'h00;
            if (op == 3'd3 || op == 3'd4 || op == 3'd5) begin
                expAddr.push_back(pc);
                imv = mem[pc];
                pc = pc + 8'd1;
            end
            case (op)
                3'd0: begin
                    r = mRegs[rd] + mRegs[rs];
                    mV = (mRegs[rd][7] == mRegs[rs][7]) && (r[7] != mRegs[rd][7]);
                    mZ = (r == 8'h00);
                    mRegs[rd] = r;
                end
                3'd1: begin r = mRegs[rd] & mRegs[rs]; mV = 1'b0; mZ = (r == 8'h00); mRegs[rd] = r; end
                3'd2: begin r = ~mRegs[rd]; mV = 1'b0; mZ = (r == 8'h00); mRegs[rd] = r; end
                3'd3: mRegs[rd] = imv;
                3'd4: if (mZ) pc = imv;
                3'd5: pc = imv;
                3'd7: mHalt = 1'b1;
                default: ;
            endcase
        end
        mPc = pc;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) initRegs[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;

        vecs[0] = mkVec(48'h687F70010C00, 5, 8'hC0, 8'h00, 5, 8'h05, 1'b0, 1'b1, 1, 8'h80);
        vecs[1] = mkVec(48'h208010000000, 3, 8'hC0, 8'h00, 3, 8'h10, 1'b1, 1'b0, 0, 8'h00);
        vecs[2] = mkVec(48'h208010000000, 3, 8'hC0, 8'h55, 3, 8'h03, 1'b0, 1'b0, 0, 8'h55);
        vecs[3] = mkVec(48'h500000000000, 1, 8'hC0, 8'hFF, 1, 8'h01, 1'b1, 1'b0, 2, 8'h00);
        vecs[4] = mkVec(48'hC0A040000000, 3, 8'hC0, 8'h33, 3, 8'h40, 1'b0, 1'b0, 0, 8'h33);
        vecs[5] = mkVec(48'hAAFF00000000, 2, 8'h78, 8'h11, 4, 8'h01, 1'b0, 1'b0, 3, 8'hAA);
        vecs[6] = mkVec(48'h600300000000, 3, 8'hC0, 8'h11, 3, 8'h03, 1'b0, 1'b0, 0, 8'h06);
        vecs[7] = mkVec(48'h0C0000000000, 1, 8'hC0, 8'h80, 1, 8'h01, 1'b1, 1'b1, 1, 8'h00);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
            for (int i = 0; i < vecs[v].progLen; i++) mem[i] = vecs[v].prog[47 - 8*i -: 8];
            mem[255] = vecs[v].hiByte;
            for (int i = 0; i < 4; i++) initRegs[i] = vecs[v].rinit;
            applyReset();
            applyStimulus(vecs[v].nFetch);
            checkOutput($sformatf("vec%0d pc", v), imem_addr, vecs[v].expPc);
            checkOutput($sformatf("vec%0d z", v), z_flag, vecs[v].expZ);
            checkOutput($sformatf("vec%0d v", v), v_flag, vecs[v].expV);
            checkOutput($sformatf("vec%0d reg", v), hregs[vecs[v].regIdx], vecs[v].expReg);
        end

        // Fetch stalls indefinitely while memory withholds ack.
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
        applyReset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stallHold", {imem_req, imem_addr, rf_we}, {1'b1, 8'h00, 1'b0});
        end

        // HALT is terminal until reset, then fetch resumes from 0.
        mem[0] = 8'hE0;
        applyReset();
        applyStimulus(1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("haltHold", {halted, imem_req, imem_addr}, {1'b1, 1'b0, 8'h01});
        end
        @(negedge clk);
        rst_n = 1'b0;
        ackEnable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("haltReset", {halted, imem_req, imem_addr}, {1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("haltResume", imem_req, 1);

        // Reset during EXEC of ADD aborts the write and clears flags.
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
        mem[0] = 8'h0C;
        mem[1] = 8'h0C;
        for (int i = 0; i < 4; i++) initRegs[i] = 8'h40;
        applyReset();
        ackLimit  = 2;
        ackEnable = 1'b1;
        waitRfWe();
        @(posedge clk);
        #1;
        checkOutput("firstAddV", v_flag, 1);
        checkOutput("firstAddR1", hregs[1], 8'h80);
        waitRfWe();
        rst_n = 1'b0;
        ackEnable = 1'b0;
        #1;
        checkOutput("weGatedByReset", rf_we, 0);
        @(posedge clk);
        #1;
        checkOutput("abortR1", hregs[1], 8'h80);
        checkOutput("abortFlags", {z_flag, v_flag}, 0);
        checkOutput("abortState", {imem_req, halted, imem_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortResume", imem_req, 1);

        // Random programs against the instruction-level model.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) initRegs[i] = 8'($urandom_range(0, 255));
            buildModel();
            applyReset();
            applyStimulus(expAddr.size());
            checkOutput($sformatf("rnd%0d fetchCount", t), gotAddr.size(), expAddr.size());
            for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++)
                checkOutput($sformatf("rnd%0d fetchAddr%0d", t, i), gotAddr[i], expAddr[i]);
            checkOutput($sformatf("rnd%0d pc", t), imem_addr, mPc);
            checkOutput($sformatf("rnd%0d z", t), z_flag, mZ);
            checkOutput($sformatf("rnd%0d v", t), v_flag, mV);
            checkOutput($sformatf("rnd%0d halted", t), halted, mHalt);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("rnd%0d r%0d", t, i), hregs[i], mRegs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
